// File: rtl/q_action_select_pkg.sv
// Shared types for the Q-learning action selector: FSM states, wide compare type
// and the signed/unsigned Q comparison.
package q_action_select_pkg;

  localparam int unsigned Q_MAXW = 64;

  typedef logic [Q_MAXW-1:0] q_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fsm_t;

  // Operands arrive already sign- or zero-extended to Q_MAXW by the caller.
  function automatic logic q_gt(input q_t a, input q_t b, input logic signed_mode);
    if (signed_mode) return $signed(a) > $signed(b);
    else             return a > b;
  endfunction

endpackage

// File: rtl/q_action_select_if.sv
// Request/result and Q-table read bus of the action selector.
interface q_action_select_if #(
  parameter int unsigned NUM_STATES  = 37,
  parameter int unsigned NUM_ACTIONS = 4,
  parameter int unsigned QW          = 32
);
  localparam int unsigned SW = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1;
  localparam int unsigned AW = $clog2(NUM_ACTIONS);

  logic                   start;
  logic [SW-1:0]          state;
  logic [NUM_ACTIONS-1:0] act_mask;
  logic [7:0]             eps;
  logic                   q_rd_en;
  logic [SW-1:0]          q_rd_state;
  logic [AW-1:0]          q_rd_act;
  logic [QW-1:0]          q_rd_data;
  logic                   busy;
  logic                   done;
  logic [AW-1:0]          action;
  logic [QW-1:0]          max_q;
  logic                   explored;
  logic                   none_valid;

  modport slave (
    input  start, state, act_mask, eps, q_rd_data,
    output q_rd_en, q_rd_state, q_rd_act, busy, done, action, max_q, explored, none_valid
  );

  modport master (
    output start, state, act_mask, eps, q_rd_data,
    input  q_rd_en, q_rd_state, q_rd_act, busy, done, action, max_q, explored, none_valid
  );
endinterface

// File: rtl/q_action_select_lfsr16.sv
// Free-running 16-bit Galois LFSR (x^16+x^14+x^13+x^11); exposes the low OUT_W bits.
module q_lfsr16 #(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int unsigned OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [OUT_W-1:0] o_lfsr
);

  logic [15:0] r_lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_lfsr <= SEED;
    else        r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  assign o_lfsr = r_lfsr[OUT_W-1:0];

endmodule

// File: rtl/q_action_select.sv
// Epsilon-greedy action selector: scans one Q-table row, returns the greedy
// argmax/max over legal actions, optionally substituting an exploratory action.
module q_action_select
  import q_action_select_pkg::*;
#(
  parameter int unsigned NUM_STATES  = 37,
  parameter int unsigned NUM_ACTIONS = 4,
  parameter int unsigned QW          = 32,
  parameter bit          Q_SIGNED    = 1'b0,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input logic                 clk,
  input logic                 rst_n,
  q_action_select_if.slave    bus
);

  localparam int unsigned NA  = NUM_ACTIONS;
  localparam int unsigned SW  = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1;
  localparam int unsigned AW  = $clog2(NUM_ACTIONS);
  localparam int unsigned LW  = AW + 8;

  fsm_t            r_state, w_state_nxt;
  logic            r_rd_en, w_rd_en_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_done, w_done_nxt;
  logic [AW-1:0]   r_rd_act;
  logic [SW-1:0]   r_q_state;
  logic [NA-1:0]   r_mask;
  logic            r_explore;
  logic [AW-1:0]   r_exp_act;
  logic            r_cmp_vld;
  logic [AW-1:0]   r_cmp_idx;
  logic            r_have;
  logic [QW-1:0]   r_max;
  logic [AW-1:0]   r_arg;
  logic [AW-1:0]   r_action;
  logic [QW-1:0]   r_max_q;
  logic            r_explored;
  logic            r_none;

  logic [LW-1:0]   w_lfsr;
  logic [AW-1:0]   w_cand;
  logic            w_start_acc;
  logic            w_explore;
  logic [AW-1:0]   w_exp_act;
  logic [AW-1:0]   w_scan;
  logic            w_found;
  q_t              w_data_x;
  q_t              w_max_x;
  logic            w_legal;
  logic            w_take;
  logic [QW-1:0]   w_max_nxt;
  logic [AW-1:0]   w_arg_nxt;
  logic            w_have_nxt;

  q_lfsr16 #(.SEED(LFSR_SEED), .OUT_W(LW)) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .o_lfsr (w_lfsr)
  );

  assign w_cand      = w_lfsr[LW-1:8];
  assign w_start_acc = (r_state == IDLE) && bus.start;
  assign w_explore   = (w_lfsr[7:0] < bus.eps) && (|bus.act_mask);

  // Exploratory pick: candidate if legal, else first legal index above it (wrapping).
  always_comb begin
    w_exp_act = w_cand;
    w_found   = 1'b0;
    w_scan    = '0;
    for (int i = 0; i < int'(NA); i++) begin
      w_scan = AW'((32'(w_cand) + 32'(i)) % NA);
      if (!w_found && bus.act_mask[w_scan]) begin
        w_exp_act = w_scan;
        w_found   = 1'b1;
      end
    end
  end

  if (Q_SIGNED) begin : g_sext
    assign w_data_x = q_t'($signed(bus.q_rd_data));
    assign w_max_x  = q_t'($signed(r_max));
  end else begin : g_zext
    assign w_data_x = q_t'(bus.q_rd_data);
    assign w_max_x  = q_t'(r_max);
  end

  // Strict greater-than keeps the lowest index on ties.
  assign w_legal    = r_cmp_vld && r_mask[r_cmp_idx];
  assign w_take     = w_legal && (!r_have || q_gt(w_data_x, w_max_x, Q_SIGNED));
  assign w_max_nxt  = w_take ? bus.q_rd_data : r_max;
  assign w_arg_nxt  = w_take ? r_cmp_idx : r_arg;
  assign w_have_nxt = r_have | w_legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rd_en_nxt = 1'b0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt = READ;
          w_rd_en_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
        end
      end
      READ: begin
        w_busy_nxt = 1'b1;
        if (r_rd_act == AW'(NA - 1)) w_state_nxt = DRAIN;
        else                         w_rd_en_nxt = 1'b1;
      end
      DRAIN: begin
        w_state_nxt = DONE;
        w_done_nxt  = 1'b1;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_en    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_act   <= '0;
      r_q_state  <= '0;
      r_mask     <= '0;
      r_explore  <= 1'b0;
      r_exp_act  <= '0;
      r_cmp_vld  <= 1'b0;
      r_cmp_idx  <= '0;
      r_have     <= 1'b0;
      r_max      <= '0;
      r_arg      <= '0;
      r_action   <= '0;
      r_max_q    <= '0;
      r_explored <= 1'b0;
      r_none     <= 1'b0;
    end else begin
      r_rd_en   <= w_rd_en_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_cmp_vld <= r_rd_en;
      r_cmp_idx <= r_rd_act;
      if (w_start_acc) begin
        r_q_state <= bus.state;
        r_mask    <= bus.act_mask;
        r_explore <= w_explore;
        r_exp_act <= w_exp_act;
        r_rd_act  <= '0;
        r_have    <= 1'b0;
        r_max     <= '0;
        r_arg     <= '0;
      end else begin
        if ((r_state == READ) && (r_rd_act != AW'(NA - 1))) r_rd_act <= r_rd_act + AW'(1);
        r_have <= w_have_nxt;
        r_max  <= w_max_nxt;
        r_arg  <= w_arg_nxt;
      end
      // Results latch together with the final compare, valid while done is high.
      if (r_state == DRAIN) begin
        if (r_mask == '0) begin
          r_action   <= '0;
          r_max_q    <= '0;
          r_explored <= 1'b0;
          r_none     <= 1'b1;
        end else begin
          r_action   <= r_explore ? r_exp_act : w_arg_nxt;
          r_max_q    <= w_max_nxt;
          r_explored <= r_explore;
          r_none     <= 1'b0;
        end
      end
    end
  end

  assign bus.q_rd_en    = r_rd_en;
  assign bus.q_rd_state = r_q_state;
  assign bus.q_rd_act   = r_rd_act;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.action     = r_action;
  assign bus.max_q      = r_max_q;
  assign bus.explored   = r_explored;
  assign bus.none_valid = r_none;

endmodule

// File: tb/tb_q_action_select.sv
// Directed bench for q_action_select: unsigned and signed instances share one Q row.
module tb_q_action_select;

  localparam int unsigned NS = 37;
  localparam int unsigned NA = 4;
  localparam int unsigned QW = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  logic [31:0] row [4];
  logic [15:0] m_lfsr;

  always #5 clk = ~clk;

  q_action_select_if #(.NUM_STATES(NS), .NUM_ACTIONS(NA), .QW(QW)) ifu ();
  q_action_select_if #(.NUM_STATES(NS), .NUM_ACTIONS(NA), .QW(QW)) ifs ();

  q_action_select #(.NUM_STATES(NS), .NUM_ACTIONS(NA), .QW(QW), .Q_SIGNED(1'b0),
                    .LFSR_SEED(16'hACE1)) u_dut_u (.clk(clk), .rst_n(rst_n), .bus(ifu.slave));
  q_action_select #(.NUM_STATES(NS), .NUM_ACTIONS(NA), .QW(QW), .Q_SIGNED(1'b1),
                    .LFSR_SEED(16'hACE1)) u_dut_s (.clk(clk), .rst_n(rst_n), .bus(ifs.slave));

  // Q-table row model: one-cycle read latency
  always @(posedge clk) begin
    if (ifu.q_rd_en) ifu.q_rd_data <= row[ifu.q_rd_act];
    if (ifs.q_rd_en) ifs.q_rd_data <= row[ifs.q_rd_act];
  end

  // Reference LFSR to predict the exploration decision at a start edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  task automatic drive(input logic s, input logic [3:0] mask, input logic [7:0] eps);
    ifu.start = s; ifu.act_mask = mask; ifu.eps = eps; ifu.state = 6'd17;
    ifs.start = s; ifs.act_mask = mask; ifs.eps = eps; ifs.state = 6'd17;
  endtask

  // Called right after a negedge; returns cycle number of done (-1 on timeout).
  task automatic do_op(input logic [3:0] mask, input logic [7:0] eps, output int lat);
    drive(1'b1, mask, eps);
    lat = -1;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(negedge clk);
      if (c == 1) drive(1'b0, mask, eps);
      if (ifu.done) lat = c;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 4'b0000, 8'd0);
    repeat (3) @(negedge clk);
    n_vec++;
    if ({ifu.busy, ifu.done, ifu.q_rd_en, ifu.explored, ifu.none_valid} !== 5'b0) begin
      n_err++; $display("FAIL reset_flags got %b want 00000",
                        {ifu.busy, ifu.done, ifu.q_rd_en, ifu.explored, ifu.none_valid});
    end
    n_vec++;
    if (ifu.action !== 2'd0) begin n_err++; $display("FAIL reset_action got %0d want 0", ifu.action); end
    n_vec++;
    if (ifu.max_q !== 32'd0) begin n_err++; $display("FAIL reset_max_q got %0h want 0", ifu.max_q); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_greedy();
    int lat;
    row = '{32'd5, 32'd9, 32'd3, 32'd7};
    drive(1'b1, 4'b1111, 8'd0);
    @(negedge clk);
    drive(1'b0, 4'b1111, 8'd0);
    n_vec++;
    if ({ifu.busy, ifu.q_rd_en, ifu.done} !== 3'b110) begin
      n_err++; $display("FAIL greedy_cycle1 busy/rd_en/done got %b want 110", {ifu.busy, ifu.q_rd_en, ifu.done});
    end
    lat = -1;
    for (int c = 2; c <= 40 && lat < 0; c++) begin
      @(negedge clk);
      if (ifu.done) lat = c;
    end
    @(negedge clk);
    n_vec++;
    if (lat != 6) begin n_err++; $display("FAIL greedy_latency got %0d want 6", lat); end
    n_vec++;
    if (ifu.action !== 2'd1) begin n_err++; $display("FAIL greedy_action got %0d want 1", ifu.action); end
    n_vec++;
    if (ifu.max_q !== 32'd9) begin n_err++; $display("FAIL greedy_max_q got %0d want 9", ifu.max_q); end
    n_vec++;
    if ({ifu.explored, ifu.none_valid} !== 2'b00) begin
      n_err++; $display("FAIL greedy_flags got %b want 00", {ifu.explored, ifu.none_valid});
    end
    n_vec++;
    if (ifu.q_rd_state !== 6'd17) begin n_err++; $display("FAIL greedy_rd_state got %0d want 17", ifu.q_rd_state); end
    row = '{32'd2, 32'd4, 32'd11, 32'd6};
    do_op(4'b1111, 8'd0, lat);
    n_vec++;
    if ({ifu.action, ifu.max_q} !== {2'd2, 32'd11}) begin
      n_err++; $display("FAIL greedy2 got act=%0d max=%0d want act=2 max=11", ifu.action, ifu.max_q);
    end
  endtask

  task automatic test_tie();
    int lat;
    row = '{32'd8, 32'd8, 32'd2, 32'd8};
    do_op(4'b1111, 8'd0, lat);
    n_vec++;
    if ({ifu.action, ifu.max_q} !== {2'd0, 32'd8}) begin
      n_err++; $display("FAIL tie_full got act=%0d max=%0d want act=0 max=8", ifu.action, ifu.max_q);
    end
    do_op(4'b1110, 8'd0, lat);
    n_vec++;
    if ({ifu.action, ifu.max_q} !== {2'd1, 32'd8}) begin
      n_err++; $display("FAIL tie_masked got act=%0d max=%0d want act=1 max=8", ifu.action, ifu.max_q);
    end
  endtask

  task automatic test_mask();
    int lat;
    row = '{32'd50, 32'd1, 32'd2, 32'd3};
    do_op(4'b0110, 8'd0, lat);
    n_vec++;
    if ({ifu.action, ifu.max_q} !== {2'd2, 32'd2}) begin
      n_err++; $display("FAIL mask_0110 got act=%0d max=%0d want act=2 max=2", ifu.action, ifu.max_q);
    end
    do_op(4'b1000, 8'd0, lat);
    n_vec++;
    if ({ifu.action, ifu.max_q} !== {2'd3, 32'd3}) begin
      n_err++; $display("FAIL mask_1000 got act=%0d max=%0d want act=3 max=3", ifu.action, ifu.max_q);
    end
    do_op(4'b0000, 8'hFF, lat);
    n_vec++;
    if (lat != 6) begin n_err++; $display("FAIL mask_none_latency got %0d want 6", lat); end
    n_vec++;
    if ({ifu.none_valid, ifu.explored, ifu.action} !== 4'b1000) begin
      n_err++; $display("FAIL mask_none_flags got nv/exp/act=%b want 1000", {ifu.none_valid, ifu.explored, ifu.action});
    end
    n_vec++;
    if (ifu.max_q !== 32'd0) begin n_err++; $display("FAIL mask_none_max_q got %0d want 0", ifu.max_q); end
  endtask

  task automatic test_signed();
    int lat;
    row = '{32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFF7, 32'hFFFF_FFFE};
    do_op(4'b1111, 8'd0, lat);
    n_vec++;
    if ({ifs.action, ifs.max_q} !== {2'd1, 32'hFFFF_FFFF}) begin
      n_err++; $display("FAIL signed_neg got act=%0d max=%0h want act=1 max=ffffffff", ifs.action, ifs.max_q);
    end
    n_vec++;
    if ({ifu.action, ifu.max_q} !== {2'd1, 32'hFFFF_FFFF}) begin
      n_err++; $display("FAIL unsigned_neg got act=%0d max=%0h want act=1 max=ffffffff", ifu.action, ifu.max_q);
    end
    row = '{32'd5, 32'hFFFF_FFFD, 32'd2, 32'd1};
    do_op(4'b1111, 8'd0, lat);
    n_vec++;
    if ({ifs.action, ifs.max_q} !== {2'd0, 32'd5}) begin
      n_err++; $display("FAIL signed_mixed got act=%0d max=%0h want act=0 max=5", ifs.action, ifs.max_q);
    end
    n_vec++;
    if ({ifu.action, ifu.max_q} !== {2'd1, 32'hFFFF_FFFD}) begin
      n_err++; $display("FAIL unsigned_mixed got act=%0d max=%0h want act=1 max=fffffffd", ifu.action, ifu.max_q);
    end
  endtask

  task automatic test_explore();
    int   lat;
    logic hit;
    logic [15:0] v;
    logic exp_x;
    logic [1:0] exp_a;
    row = '{32'd1, 32'd6, 32'd2, 32'd0};
    hit = 1'b0;
    for (int c = 0; c < 4000 && !hit; c++) begin
      v = m_lfsr;
      if (v[7:0] < 8'h20 && v[9:8] == 2'd3) hit = 1'b1;
      else @(negedge clk);
    end
    n_vec++;
    if (!hit) begin n_err++; $display("FAIL explore_seed got no match want match"); end
    do_op(4'b0111, 8'h20, lat);
    n_vec++;
    if ({ifu.explored, ifu.action} !== 3'b100) begin
      n_err++; $display("FAIL explore_wrap got exp/act=%b want 100", {ifu.explored, ifu.action});
    end
    n_vec++;
    if (ifu.max_q !== 32'd6) begin n_err++; $display("FAIL explore_max_q got %0d want 6", ifu.max_q); end
    v = m_lfsr;
    exp_x = (v[7:0] < 8'h80);
    exp_a = exp_x ? v[9:8] : 2'd1;
    do_op(4'b1111, 8'h80, lat);
    n_vec++;
    if ({ifu.explored, ifu.action, ifu.max_q} !== {exp_x, exp_a, 32'd6}) begin
      n_err++; $display("FAIL explore_half got exp=%b act=%0d max=%0d want exp=%b act=%0d max=6",
                        ifu.explored, ifu.action, ifu.max_q, exp_x, exp_a);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int ndone;
    row = '{32'd5, 32'd9, 32'd3, 32'd7};
    drive(1'b1, 4'b1111, 8'd0);
    @(negedge clk);
    drive(1'b0, 4'b1111, 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({ifu.busy, ifu.done, ifu.q_rd_en, ifu.explored, ifu.none_valid} !== 5'b0) begin
      n_err++; $display("FAIL rstmid_flags got %b want 00000",
                        {ifu.busy, ifu.done, ifu.q_rd_en, ifu.explored, ifu.none_valid});
    end
    n_vec++;
    if ({ifu.action, ifu.max_q} !== 34'd0) begin
      n_err++; $display("FAIL rstmid_result got act=%0d max=%0d want 0 0", ifu.action, ifu.max_q);
    end
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (ifu.done) ndone++;
      if (c == 3) rst_n = 1'b1;
    end
    n_vec++;
    if (ndone != 0) begin n_err++; $display("FAIL rstmid_no_done got %0d dones want 0", ndone); end
    do_op(4'b1111, 8'd0, lat);
    n_vec++;
    if ({ifu.action, ifu.max_q} !== {2'd1, 32'd9} || lat != 6) begin
      n_err++; $display("FAIL rstmid_rerun got act=%0d max=%0d lat=%0d want act=1 max=9 lat=6",
                        ifu.action, ifu.max_q, lat);
    end
  endtask

  task automatic test_busy_start();
    int  ndone;
    logic pulse;
    row = '{32'd4, 32'd1, 32'd7, 32'd7};
    drive(1'b1, 4'b1111, 8'd0);
    ndone = 0;
    pulse = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) drive(1'b0, 4'b1111, 8'd0);
      if (c == 2) drive(1'b1, 4'b0001, 8'd0);
      if (c == 3) drive(1'b0, 4'b0001, 8'd0);
      if (pulse) begin drive(1'b0, 4'b0001, 8'd0); pulse = 1'b0; end
      if (ifu.done) begin ndone++; drive(1'b1, 4'b0001, 8'd0); pulse = 1'b1; end
    end
    n_vec++;
    if (ndone != 1) begin n_err++; $display("FAIL busy_one_done got %0d want 1", ndone); end
    n_vec++;
    if ({ifu.action, ifu.max_q, ifu.busy} !== {2'd2, 32'd7, 1'b0}) begin
      n_err++; $display("FAIL busy_result got act=%0d max=%0d busy=%b want act=2 max=7 busy=0",
                        ifu.action, ifu.max_q, ifu.busy);
    end
  endtask

  initial begin
    ifu.q_rd_data = '0;
    ifs.q_rd_data = '0;
    row = '{32'd0, 32'd0, 32'd0, 32'd0};
    test_reset();
    test_greedy();
    test_tie();
    test_mask();
    test_signed();
    test_explore();
    test_reset_mid();
    test_busy_start();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

endmodule
